// File: rtl/lsu_if.sv
// lsu_if: groups the execute-side operation handshake and the data-memory
// request/grant/response bus of the load/store unit.
//   slave  : the view taken by lsu (consumes operations, drives memory requests)
//   master : the view taken by the surrounding stage / memory model
// Signals:
//   valid_in, we_in, funct3_in, addr_in, wdata_in   operation from execute
//   stall_out, done_out, err_out, rdata_out         status/result to pipeline
//   mem_req_out, mem_we_out, mem_addr_out,
//   mem_be_out, mem_wdata_out                       request to data memory
//   mem_gnt_in, mem_rvalid_in, mem_rdata_in         grant/response from memory
interface lsu_if #(parameter int ARCH = 32);
  logic            valid_in;
  logic            we_in;
  logic [2:0]      funct3_in;
  logic [ARCH-1:0] addr_in;
  logic [ARCH-1:0] wdata_in;
  logic            stall_out;
  logic            done_out;
  logic            err_out;
  logic [ARCH-1:0] rdata_out;
  logic            mem_req_out;
  logic            mem_we_out;
  logic [ARCH-1:0] mem_addr_out;
  logic [3:0]      mem_be_out;
  logic [ARCH-1:0] mem_wdata_out;
  logic            mem_gnt_in;
  logic            mem_rvalid_in;
  logic [ARCH-1:0] mem_rdata_in;

  modport slave (
    input  valid_in, we_in, funct3_in, addr_in, wdata_in,
    input  mem_gnt_in, mem_rvalid_in, mem_rdata_in,
    output stall_out, done_out, err_out, rdata_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out
  );

  modport master (
    output valid_in, we_in, funct3_in, addr_in, wdata_in,
    output mem_gnt_in, mem_rvalid_in, mem_rdata_in,
    input  stall_out, done_out, err_out, rdata_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_be_out, mem_wdata_out
  );
endinterface

// File: rtl/lsu.sv
// lsu: RV32I load/store unit. Takes the ALU result as effective address,
// runs a request/grant/response transaction with data memory, formats byte
// enables and lane-replicated store data, and sign/zero-extends load data.
// Misaligned or illegal operations complete with err_out without a request.
// Ports:
//   clk_in  clock, rising edge
//   rst_in  asynchronous active-high reset
//   bus     lsu_if.slave (execute handshake + memory bus)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; may accept an operation when done_out is low
// REQ   | mem_req_out held with stable request until mem_gnt_in
// WAIT  | granted; waiting for mem_rvalid_in to complete the operation
module lsu #(
  parameter int ARCH = 32
) (
  input  logic  clk_in,
  input  logic  rst_in,
  lsu_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state, state_n;
  logic            done_q, done_n;
  logic            err_q, err_n;
  logic [ARCH-1:0] rdata_q, rdata_n;
  logic            req_q, req_n;
  logic            we_q, we_n;
  logic [ARCH-1:0] addr_q, addr_n;
  logic [3:0]      be_q, be_n;
  logic [ARCH-1:0] wdata_q, wdata_n;
  logic [2:0]      f3_q, f3_n;
  logic [1:0]      lane_q, lane_n;

  logic            accept;
  logic            size_ok;
  logic            type_ok;
  logic [3:0]      fmt_be;
  logic [ARCH-1:0] fmt_wdata;
  logic [ARCH-1:0] shifted;
  logic [ARCH-1:0] load_val;

  // Done_out blocks re-accept so back-to-back ops get one idle cycle
  // while the upstream stage advances.
  assign accept        = (state == S_IDLE) && bus.valid_in && !done_q;
  assign bus.stall_out = (state != S_IDLE) || accept;

  assign bus.done_out      = done_q;
  assign bus.err_out       = err_q;
  assign bus.rdata_out     = rdata_q;
  assign bus.mem_req_out   = req_q;
  assign bus.mem_we_out    = we_q;
  assign bus.mem_addr_out  = addr_q;
  assign bus.mem_be_out    = be_q;
  assign bus.mem_wdata_out = wdata_q;

  always_comb begin
    size_ok   = 1'b0;
    fmt_be    = 4'b1111;
    fmt_wdata = bus.wdata_in;
    case (bus.funct3_in[1:0])
      2'b00: begin
        size_ok   = 1'b1;
        fmt_be    = 4'b0001 << bus.addr_in[1:0];
        fmt_wdata = {4{bus.wdata_in[7:0]}};
      end
      2'b01: begin
        size_ok   = ~bus.addr_in[0];
        fmt_be    = bus.addr_in[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{bus.wdata_in[15:0]}};
      end
      2'b10: begin
        size_ok = (bus.addr_in[1:0] == 2'b00);
      end
      default: size_ok = 1'b0;
    endcase
    // Stores have no unsigned forms; loads reject 110/111 (011 fails size).
    type_ok = bus.we_in ? ~bus.funct3_in[2] : ~(bus.funct3_in[2] & bus.funct3_in[1]);
  end

  always_comb begin
    shifted  = bus.mem_rdata_in >> {lane_q, 3'b000};
    load_val = shifted;
    case (f3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'h0, shifted[7:0]};
      3'b101:  load_val = {16'h0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    err_n   = 1'b0;
    rdata_n = rdata_q;
    req_n   = req_q;
    we_n    = we_q;
    addr_n  = addr_q;
    be_n    = be_q;
    wdata_n = wdata_q;
    f3_n    = f3_q;
    lane_n  = lane_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (size_ok && type_ok) begin
            state_n = S_REQ;
            req_n   = 1'b1;
            we_n    = bus.we_in;
            addr_n  = {bus.addr_in[ARCH-1:2], 2'b00};
            be_n    = fmt_be;
            wdata_n = bus.we_in ? fmt_wdata : '0;
            f3_n    = bus.funct3_in;
            lane_n  = bus.addr_in[1:0];
          end else begin
            done_n = 1'b1;
            err_n  = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt_in) begin
          req_n   = 1'b0;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_in) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
          if (!we_q) rdata_n = load_val;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      lane_q  <= 2'b00;
    end else begin
      state   <= state_n;
      done_q  <= done_n;
      err_q   <= err_n;
      rdata_q <= rdata_n;
      req_q   <= req_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      be_q    <= be_n;
      wdata_q <= wdata_n;
      f3_q    <= f3_n;
      lane_q  <= lane_n;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed, table-driven bench for lsu with a cycle-level memory
// responder plus hand-written reset sequences.
module tb_lsu;

  logic clk = 1'b0;
  logic rst;

  lsu_if #(.ARCH(32)) bus ();

  lsu #(.ARCH(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_rdata = 32'h0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          gd;
    int          rd;
    logic        eerr;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic [31:0] erdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int done_cyc = -1;
    int stall_cnt = 0;
    int req_k = 0;
    int wait_k = 0;
    int unstable = 0;
    bit gnt_given = 0;
    bit req_seen = 0;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = 32'h0;
    logic [31:0] exp_addr;
    logic        stall_at_done = 1'b1;
    exp_addr = {v.addr[31:2], 2'b00};

    @(posedge clk); #1;
    bus.valid_in     = 1'b1;
    bus.we_in        = v.we;
    bus.funct3_in    = v.f3;
    bus.addr_in      = v.addr;
    bus.wdata_in     = v.wdata;
    bus.mem_rdata_in = v.mrdata;

    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus.mem_gnt_in    = 1'b0;
      bus.mem_rvalid_in = 1'b0;
      if (bus.done_out) begin
        done_cyc      = c;
        got_err       = bus.err_out;
        got_rdata     = bus.rdata_out;
        stall_at_done = bus.stall_out;
        break;
      end
      if (bus.stall_out) stall_cnt++;
      if (bus.mem_req_out) begin
        req_seen = 1;
        if (bus.mem_addr_out !== exp_addr || bus.mem_be_out !== v.ebe ||
            bus.mem_we_out !== v.we || bus.mem_wdata_out !== v.ewdata)
          unstable++;
        if (req_k == v.gd) begin
          bus.mem_gnt_in = 1'b1;
          gnt_given = 1;
        end
        req_k++;
      end else if (gnt_given) begin
        if (wait_k == v.rd) bus.mem_rvalid_in = 1'b1;
        wait_k++;
      end
    end

    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    bus.mem_gnt_in = 1'b0;
    bus.mem_rvalid_in = 1'b0;

    if (v.eerr) begin
      chk({v.name, " done_cycle"}, done_cyc, 1);
      chk({v.name, " err"}, {31'h0, got_err}, 32'h1);
      chk({v.name, " no_req"}, {31'h0, req_seen}, 32'h0);
      chk({v.name, " stall_cycles"}, stall_cnt, 1);
    end else begin
      chk({v.name, " done_cycle"}, done_cyc, 3 + v.gd + v.rd);
      chk({v.name, " err"}, {31'h0, got_err}, 32'h0);
      chk({v.name, " stall_cycles"}, stall_cnt, 3 + v.gd + v.rd);
      chk({v.name, " req_cycles"}, req_k, v.gd + 1);
      chk({v.name, " mem_fields_bad_cycles"}, unstable, 0);
      if (v.we) begin
        chk({v.name, " rdata_held"}, got_rdata, last_rdata);
      end else begin
        chk({v.name, " rdata"}, got_rdata, v.erdata);
        last_rdata = v.erdata;
      end
    end
    chk({v.name, " stall_at_done"}, {31'h0, stall_at_done}, 32'h0);

    @(negedge clk);
    chk({v.name, " done_one_cycle"}, {31'h0, bus.done_out}, 32'h0);
    chk({v.name, " no_reaccept"}, {31'h0, bus.mem_req_out}, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst               = 1'b1;
    bus.valid_in      = 1'b0;
    bus.we_in         = 1'b0;
    bus.funct3_in     = 3'b000;
    bus.addr_in       = 32'h0;
    bus.wdata_in      = 32'h0;
    bus.mem_gnt_in    = 1'b0;
    bus.mem_rvalid_in = 1'b0;
    bus.mem_rdata_in  = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset stall", {31'h0, bus.stall_out}, 32'h0);
    chk("reset done", {31'h0, bus.done_out}, 32'h0);
    chk("reset err", {31'h0, bus.err_out}, 32'h0);
    chk("reset mem_req", {31'h0, bus.mem_req_out}, 32'h0);
    chk("reset rdata", bus.rdata_out, 32'h0);
    rst = 1'b0;

    //          name          we    f3      addr          wdata         mrdata        gd rd err   be       ewdata        erdata
    vecs[0]  = '{"lw_min",    1'b0, 3'b010, 32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{"lb_lane3",  1'b0, 3'b000, 32'h0000_2003, 32'h0,        32'h8012_3456, 0, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{"lbu_lane3", 1'b0, 3'b100, 32'h0000_2003, 32'h0,        32'h8012_3456, 0, 1, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[3]  = '{"sh_gnt3",   1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_5555, 3, 1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
    vecs[4]  = '{"lw_mis",    1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{"ld_f3_011", 1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{"lh_lane2",  1'b0, 3'b001, 32'h0000_4002, 32'h0,        32'h8001_7FFF, 1, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
    vecs[7]  = '{"lhu_lane0", 1'b0, 3'b101, 32'h0000_4000, 32'h0,        32'h8001_F00D, 0, 2, 1'b0, 4'b0011, 32'h0,        32'h0000_F00D};
    vecs[8]  = '{"sb_lane1",  1'b1, 3'b000, 32'h0000_5001, 32'hAABB_CC5A, 32'h0,         1, 2, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0};
    vecs[9]  = '{"sw",        1'b1, 3'b010, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,         0, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{"sh_mis",    1'b1, 3'b001, 32'h0000_6001, 32'h1111_2222, 32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[11] = '{"st_f3_100", 1'b1, 3'b100, 32'h0000_6000, 32'h1111_2222, 32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};
    vecs[12] = '{"lb_lane1",  1'b0, 3'b000, 32'h0000_7001, 32'h0,        32'h0000_7F00, 0, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_007F};
    vecs[13] = '{"lh_mis",    1'b0, 3'b001, 32'h0000_7001, 32'h0,        32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        32'h0};

    for (int i = 0; i < 14; i++) run_op(vecs[i]);

    // Reset while in WAIT, then a stale rvalid after release.
    @(posedge clk); #1;
    bus.valid_in     = 1'b1;
    bus.we_in        = 1'b0;
    bus.funct3_in    = 3'b010;
    bus.addr_in      = 32'h0000_8000;
    bus.mem_rdata_in = 32'h1234_5678;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwait req_up", {31'h0, bus.mem_req_out}, 32'h1);
    bus.mem_gnt_in = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt_in = 1'b0;
    @(negedge clk);
    chk("rstwait in_wait_stall", {31'h0, bus.stall_out}, 32'h1);
    rst = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    chk("rstwait stall", {31'h0, bus.stall_out}, 32'h0);
    chk("rstwait mem_req", {31'h0, bus.mem_req_out}, 32'h0);
    chk("rstwait mem_addr", bus.mem_addr_out, 32'h0);
    chk("rstwait mem_be", {28'h0, bus.mem_be_out}, 32'h0);
    chk("rstwait rdata", bus.rdata_out, 32'h0);
    chk("rstwait done", {31'h0, bus.done_out}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stale_done = 0;
      int stale_req = 0;
      for (int c = 0; c < 4; c++) begin
        bus.mem_rvalid_in = 1'b1;
        bus.mem_gnt_in    = 1'b1;
        @(negedge clk);
        if (bus.done_out) stale_done++;
        if (bus.mem_req_out || bus.stall_out) stale_req++;
      end
      bus.mem_rvalid_in = 1'b0;
      bus.mem_gnt_in    = 1'b0;
      chk("stale rvalid done", stale_done, 0);
      chk("stale req_or_stall", stale_req, 0);
      chk("stale rdata", bus.rdata_out, 32'h0);
    end

    // Unit still works after the abandoned transaction.
    run_op(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the FRiscV RV32I core, sitting directly downstream of the ALU in the execute/memory stage. It takes the ALU result as an effective address and runs a multi-cycle request/grant/response transaction with data memory. It generates byte enables and lane-replicated store data, and returns sign- or zero-extended load data. It stalls the upstream pipeline while a transaction is in flight and flags misaligned or illegal accesses without touching memory.

## Interface
- ARCH, 32, datapath width; only 32 is supported.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- valid_in  input  1  execute stage presents a memory operation; held stable until stall_out falls.
- we_in  input  1  1 = store, 0 = load.
- funct3_in  input  3  RV32I funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
- addr_in  input  ARCH  effective address, driven by the ALU result_out.
- wdata_in  input  ARCH  store data (rs2).
- stall_out  output  1  hold upstream pipeline; combinational.
- done_out  output  1  one-cycle pulse: operation finished (success or error); registered.
- err_out  output  1  qualifies done_out: misaligned or illegal access; registered.
- rdata_out  output  ARCH  extended load result; valid when done_out=1, err_out=0, op was a load; registered.
- mem_req_out  output  1  memory request; registered.
- mem_we_out  output  1  memory write enable; registered.
- mem_addr_out  output  ARCH  word-aligned address {addr[31:2],2'b00}; registered.
- mem_be_out  output  4  byte enables; registered.
- mem_wdata_out  output  ARCH  lane-replicated store data; registered.
- mem_gnt_in  input  1  memory accepts the request this cycle.
- mem_rvalid_in  input  1  response valid; arrives at least 1 cycle after gnt, for loads and stores.
- mem_rdata_in  input  ARCH  response data word.

## Operation
- FSM states: IDLE, REQ, WAIT. Reset state is IDLE.
- Reset values: all registered outputs 0; rdata_out 0.
- Acceptance: accept only in IDLE with valid_in=1 and done_out=0. Capture we, funct3, addr[1:0] and the lane-formatted request.
- Legality:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=00.
  - Loads with funct3 011/110/111 and stores with funct3 other than 000/001/010 are illegal.
- Illegal or misaligned accept: no memory request; stay in IDLE; next cycle done_out=1 and err_out=1.
- Legal accept: IDLE to REQ. The request registers load in the same edge, so mem_req_out=1 in the next cycle.
- REQ: hold mem_req_out and all mem_* outputs stable until mem_gnt_in=1. On grant, mem_req_out falls at the next edge and the FSM moves to WAIT.
- WAIT: on mem_rvalid_in=1, go to IDLE with done_out=1 and err_out=0. For loads, also register rdata_out. For stores, rdata_out holds its previous value.
- Byte enables and store data:
  - Byte: be = 0001 << addr[1:0]; wdata = {4{wdata_in[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011; wdata = {2{wdata_in[15:0]}}.
  - Word: be = 1111; wdata = wdata_in.
  - Loads drive the same be pattern; mem_wdata_out is 0.
- Load extract:
  - Take the byte/half at lane addr[1:0] of mem_rdata_in.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- stall_out = (state != IDLE) or (state == IDLE and valid_in and done_out == 0).
- mem_rvalid_in outside WAIT is ignored, including a stale response arriving after reset. mem_gnt_in outside REQ is ignored.
- Reset mid-operation: immediately IDLE, all outputs 0. The in-flight transaction is abandoned.

## Timing
- Minimum legal latency: accept at cycle 0, req at cycle 1 (gnt at 1), WAIT at cycle 2 (rvalid at 2), done_out/rdata_out at cycle 3.
- stall_out is high for cycles 0–2 and low at cycle 3.
- Each extra cycle of gnt delay or rvalid delay adds one cycle to the latency.
- Error path: accept at cycle 0, done_out=err_out=1 at cycle 1, stall_out high at cycle 0 only.
- In the done_out cycle, stall_out=0 and no new accept occurs, so back-to-back operations are separated by one cycle. The upstream stage advances on that edge.
- done_out and err_out are exactly one cycle wide.

## Test plan
- LW, addr 0x0000_1004, gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEAD_BEEF. Required: mem_addr 0x1004, be 1111, done_out and rdata_out 0xDEAD_BEEF at cycle 3, stall_out high for exactly 3 cycles.
- LB and LBU at addr 0x...03 with rdata 0x80xx_xxxx. Required: be 1000; LB gives rdata_out 0xFFFF_FF80, LBU gives 0x0000_0080.
- SH at addr 0x...02, wdata_in 0x1234_ABCD, gnt delayed 3 cycles. Required: mem_wdata 0xABCD_ABCD, be 1100, mem_we 1, all mem_* stable while waiting for grant, done_out 1 cycle after rvalid.
- LW at addr 0x...02, and load with funct3 011. Required: mem_req_out never asserted; done_out=err_out=1 next cycle; stall_out high for one cycle.
- Reset asserted while in WAIT, then rvalid pulses after reset release. Required: all outputs 0 immediately; stale rvalid ignored; no done_out.
